// File: rtl/rca_sched_pkg.sv
// rtl/rca_sched_pkg.sv - shared FSM encodings and pass-count helpers for rca_add_sched
package rca_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_SLICE = 4;
    localparam int DEF_N     = DEF_WIDTH / DEF_SLICE;

    // Number of slice passes per add; a zero slice width yields 0 so elaboration checks can reject it.
    function automatic int calc_n(input int width, input int slice);
        return (slice > 0) ? (width / slice) : 0;
    endfunction

endpackage

// File: rtl/rca4_slice.sv
// rtl/rca4_slice.sv - combinational ripple-carry adder slice
module rca4_slice #(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             c_in,
    output logic [SLICE-1:0] sum,
    output logic             c_out
);

    always_comb begin
        logic c;
        c   = c_in;
        sum = '0;
        for (int i = 0; i < SLICE; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        c_out = c;
    end

endmodule

// File: rtl/rca_add_sched.sv
// rtl/rca_add_sched.sv - two-requester round-robin adder computing one slice per cycle
module rca_add_sched
    import rca_sched_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SLICE = DEF_SLICE
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         req_valid,
    output logic [1:0]         req_ready,
    input  logic [2*WIDTH-1:0] req_a,
    input  logic [2*WIDTH-1:0] req_b,
    input  logic [1:0]         req_cin,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic               resp_id,
    output logic [WIDTH-1:0]   resp_sum,
    output logic               resp_cout,
    output logic               busy
);

    localparam int N  = calc_n(WIDTH, SLICE);
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    generate
        if (SLICE < 1 || N < 1 || (WIDTH % SLICE) != 0) begin : g_bad_params
            $error("rca_add_sched: WIDTH must be a non-zero multiple of SLICE");
        end
    endgenerate

    state_t           state;
    state_t           state_next;
    logic [KW-1:0]    k;
    logic             carry;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             id_q;
    logic             last_grant;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    logic             grant_any;
    logic             grant_id;
    logic [WIDTH-1:0] grant_a;
    logic [WIDTH-1:0] grant_b;
    logic             grant_cin;

    int               base;
    logic [SLICE-1:0] sl_a;
    logic [SLICE-1:0] sl_b;
    logic [SLICE-1:0] sl_sum;
    logic             sl_cout;

    always_comb begin
        base = int'(k) * SLICE;
        sl_a = a_q[base +: SLICE];
        sl_b = b_q[base +: SLICE];
    end

    rca4_slice #(
        .SLICE (SLICE)
    ) u_slice (
        .a     (sl_a),
        .b     (sl_b),
        .c_in  (carry),
        .sum   (sl_sum),
        .c_out (sl_cout)
    );

    // On a tie the requester that did not win last time is favoured.
    always_comb begin
        grant_any  = 1'b0;
        grant_id   = 1'b0;
        req_ready  = 2'b00;
        state_next = state;
        case (state)
            IDLE: begin
                if (req_valid != 2'b00) begin
                    grant_any  = 1'b1;
                    grant_id   = (req_valid == 2'b11) ? ~last_grant : req_valid[1];
                    req_ready  = grant_id ? 2'b10 : 2'b01;
                    state_next = ADD;
                end
            end
            ADD: begin
                if (k == K_LAST) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (rst) begin
            grant_any = 1'b0;
            req_ready = 2'b00;
        end
    end

    always_comb begin
        grant_a   = grant_id ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
        grant_b   = grant_id ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];
        grant_cin = grant_id ? req_cin[1] : req_cin[0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            k          <= '0;
            carry      <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            id_q       <= 1'b0;
            last_grant <= 1'b1;
            sum_q      <= '0;
            cout_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        a_q        <= grant_a;
                        b_q        <= grant_b;
                        carry      <= grant_cin;
                        id_q       <= grant_id;
                        last_grant <= grant_id;
                        sum_q      <= '0;
                        cout_q     <= 1'b0;
                        k          <= '0;
                    end
                end
                ADD: begin
                    sum_q[base +: SLICE] <= sl_sum;
                    carry                <= sl_cout;
                    if (k == K_LAST) begin
                        cout_q <= sl_cout;
                        k      <= '0;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign resp_valid = (state == DONE);
    assign busy       = (state != IDLE);
    assign resp_id    = id_q;
    assign resp_sum   = sum_q;
    assign resp_cout  = cout_q;

endmodule

// File: tb/tb_rca_add_sched.sv
// tb/tb_rca_add_sched.sv - scoreboard bench for rca_add_sched
module tb_rca_add_sched;

    localparam int W = 16;

    logic           clk;
    logic           rst;
    logic [1:0]     req_valid;
    logic [1:0]     req_ready;
    logic [2*W-1:0] req_a;
    logic [2*W-1:0] req_b;
    logic [1:0]     req_cin;
    logic           resp_valid;
    logic           resp_ready;
    logic           resp_id;
    logic [W-1:0]   resp_sum;
    logic           resp_cout;
    logic           busy;

    rca_add_sched #(.WIDTH(W), .SLICE(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_cin    (req_cin),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_sum   (resp_sum),
        .resp_cout  (resp_cout),
        .busy       (busy)
    );

    typedef struct {
        logic         id;
        logic [W-1:0] sum;
        logic         cout;
        int           acc_cyc;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic cin, input int acc);
        exp_t e;
        logic [W:0] full;
        full      = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        e.id      = id;
        e.sum     = full[W-1:0];
        e.cout    = full[W];
        e.acc_cyc = acc;
        sb.push_back(e);
    endtask

    // Called aligned to posedge+1; returns aligned to posedge+1 just after the accepting edge.
    task automatic do_req(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input bit expect_resp, output int acc);
        int n;
        req_a[id*W +: W] = a;
        req_b[id*W +: W] = b;
        req_cin[id]      = cin;
        req_valid[id]    = 1'b1;
        acc = -1;
        n = 0;
        @(negedge clk);
        while (req_ready == 2'b00 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (req_ready == 2'b00) begin
            check("accept_timeout", 0, 1);
        end else begin
            check("req_ready_onehot", req_ready, id ? 2'b10 : 2'b01);
            acc = cyc + 1;
            if (expect_resp) push_exp(id, a, b, cin, acc);
        end
        @(posedge clk);
        #1;
        req_valid[id] = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (busy) check("idle_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin : monitor
        static logic prev_valid = 1'b0;
        exp_t e;
        if (!rst && resp_valid && !prev_valid) begin
            if (sb.size() == 0) check("unexpected_resp", 1, 0);
            else check("resp_latency", cyc - sb[0].acc_cyc, 4);
        end
        if (!rst && resp_valid && resp_ready && sb.size() != 0) begin
            e = sb.pop_front();
            check("resp_id", resp_id, e.id);
            check("resp_sum", resp_sum, e.sum);
            check("resp_cout", resp_cout, e.cout);
        end
        prev_valid = resp_valid;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int acc0, acc1, acc, n;
        rst        = 1'b1;
        req_valid  = 2'b00;
        req_a      = '0;
        req_b      = '0;
        req_cin    = 2'b00;
        resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_resp_sum", resp_sum, 0);
        check("rst_resp_cout", resp_cout, 0);
        check("rst_resp_id", resp_id, 0);

        // Tie on the first cycle after reset: requester 0 first, requester 1 next.
        @(posedge clk);
        #1;
        rst       = 1'b0;
        req_a     = {16'h0102, 16'h1111};
        req_b     = {16'h0304, 16'h2222};
        req_cin   = 2'b10;
        req_valid = 2'b11;
        @(negedge clk);
        check("tie_first_grant", req_ready, 2'b01);
        acc0 = cyc + 1;
        push_exp(1'b0, 16'h1111, 16'h2222, 1'b0, acc0);
        @(posedge clk);
        #1;
        req_valid      = 2'b10;
        req_a[W-1:0]   = 16'hDEAD;
        @(negedge clk);
        check("ready_in_add", req_ready, 2'b00);
        n = 0;
        while (req_ready == 2'b00 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("tie_second_grant", req_ready, 2'b10);
        acc1 = cyc + 1;
        push_exp(1'b1, 16'h0102, 16'h0304, 1'b1, acc1);
        check("rr_spacing", acc1 - acc0, 6);
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        wait_idle();

        do_req(1'b0, 16'h5555, 16'hAAAA, 1'b0, 1'b1, acc);
        do_req(1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 1'b1, acc);
        do_req(1'b0, 16'h000F, 16'h0001, 1'b0, 1'b1, acc);
        do_req(1'b1, 16'h8000, 16'h8000, 1'b0, 1'b1, acc);
        for (int i = 0; i < 10; i++) begin
            do_req(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
                   1'($urandom_range(0, 1)), 1'b1, acc);
        end
        wait_idle();

        // Back-pressure in DONE with both requesters knocking.
        resp_ready = 1'b0;
        do_req(1'b1, 16'h1234, 16'h0FF0, 1'b1, 1'b1, acc);
        n = 0;
        @(negedge clk);
        while (!resp_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("bp_resp_valid_seen", resp_valid, 1);
        @(posedge clk);
        #1;
        req_valid = 2'b11;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_hold_valid", resp_valid, 1);
            check("bp_hold_sum", resp_sum, 16'h2225);
            check("bp_hold_id", resp_id, 1);
            check("bp_req_ready", req_ready, 2'b00);
        end
        @(posedge clk);
        #1;
        req_valid  = 2'b00;
        resp_ready = 1'b1;
        wait_idle();

        // Reset while slice k=2 is pending; partial sums are visible beforehand.
        do_req(1'b0, 16'h1234, 16'h4321, 1'b0, 1'b0, acc);
        @(negedge clk);
        check("sum_cleared_on_accept", resp_sum, 16'h0000);
        check("busy_in_add", busy, 1);
        @(negedge clk);
        check("partial_sum_k0", resp_sum, 16'h0005);
        @(negedge clk);
        check("partial_sum_k1", resp_sum, 16'h0055);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_busy", busy, 0);
        check("midrst_resp_valid", resp_valid, 0);
        check("midrst_resp_sum", resp_sum, 0);
        check("midrst_resp_cout", resp_cout, 0);
        repeat (8) @(negedge clk);
        check("midrst_no_resp", resp_valid, 0);

        // After reset requester 0 wins a tie again even though it won last before reset.
        @(posedge clk);
        #1;
        req_a     = {16'h0F0F, 16'h7000};
        req_b     = {16'h0101, 16'h9000};
        req_cin   = 2'b00;
        req_valid = 2'b11;
        @(negedge clk);
        check("post_rst_tie_grant", req_ready, 2'b01);
        push_exp(1'b0, 16'h7000, 16'h9000, 1'b0, cyc + 1);
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        wait_idle();
        repeat (4) @(posedge clk);
        #1;
        check("scoreboard_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rca_add_sched.md
RCA_ADD_SCHED -- requirements
Module: rca_add_sched

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, operand width in bits.
REQ-002 The block SHALL have parameter SLICE, default 4, adder slice width in bits; N = WIDTH/SLICE passes per add.
REQ-003 The block SHALL have port clk, input, 1, rising-edge clock.
REQ-004 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have port req_valid, input, 2, per-requester request valid (bit i = requester i).
REQ-006 The block SHALL have port req_ready, output, 2, per-requester accept strobe.
REQ-007 The block SHALL have port req_a, input, 2*WIDTH, operand A; requester i uses bits [i*WIDTH +: WIDTH].
REQ-008 The block SHALL have port req_b, input, 2*WIDTH, operand B; same packing as req_a.
REQ-009 The block SHALL have port req_cin, input, 2, per-requester carry-in.
REQ-010 The block SHALL have port resp_valid, output, 1, result available.
REQ-011 The block SHALL have port resp_ready, input, 1, consumer accepts result.
REQ-012 The block SHALL have port resp_id, output, 1, index of the requester owning the result.
REQ-013 The block SHALL have port resp_sum, output, WIDTH, sum bits.
REQ-014 The block SHALL have port resp_cout, output, 1, final carry-out.
REQ-015 The block SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-016 The FSM SHALL have states IDLE, ADD and DONE, registered.
REQ-017 In IDLE, when any req_valid bit is high, the block SHALL grant exactly one requester, drive req_ready one-hot for that requester combinationally, and transition to ADD on that edge.
REQ-018 req_ready SHALL be 2'b00 in ADD and DONE, and in IDLE when no request is pending.
REQ-019 Arbitration SHALL be round-robin: a single valid requester always wins; on a tie the winner is the requester not granted last.
REQ-020 On accept the block SHALL latch the granted requester's a, b, cin and id; later input changes SHALL NOT affect the operation.
REQ-021 In ADD a slice counter k (0..N-1) SHALL select bits [k*SLICE +: SLICE] of a and b, add them with the carry register (latched cin when k=0), write the slice sum into resp_sum at the same bit position, and update the carry register, once per cycle.
REQ-022 After slice N-1 is registered, the FSM SHALL enter DONE; resp_valid SHALL therefore rise exactly N clock edges after the accepting edge (4 for the default parameters).
REQ-023 resp_cout SHALL equal the carry out of slice N-1; resp_sum and resp_cout SHALL equal the full-width sum a+b+cin, modulo 2^WIDTH with the overflow bit in resp_cout.
REQ-024 In DONE, resp_valid, resp_id, resp_sum and resp_cout SHALL hold stable until resp_ready is sampled high; the FSM then returns to IDLE and resp_valid falls on that edge.
REQ-025 No new request SHALL be accepted in DONE, even when resp_ready is high; the earliest next accept is in the cycle after the DONE-to-IDLE transition (throughput of one add per N+2 cycles with no back-pressure).
REQ-026 A requester whose valid drops before it is granted SHALL simply not be served; no request is queued.
REQ-027 resp_sum SHALL be cleared to zero on accept; slices not yet computed read as zero.

Reset
REQ-028 While rst is high at a clock edge, the following SHALL be forced, overriding any in-flight operation: state to IDLE, k to 0, carry to 0, resp_valid 0, resp_id 0, resp_sum 0, resp_cout 0, busy 0, req_ready 0.
REQ-029 On reset, the last-grant register SHALL be set to 1, so that requester 0 wins the first tie.
REQ-030 An operation interrupted by reset SHALL be discarded, with no response.

Structure
REQ-031 FSM state encodings and the derived constant N SHALL live in a shared package, rca_sched_pkg.
REQ-032 The per-slice adder SHALL be a separate sub-module, rca4_slice, with ports a, b, c_in, sum and c_out, purely combinational and SLICE bits wide.
REQ-033 Elaboration SHALL fail when WIDTH is not a multiple of SLICE, or when N < 1.

Verification
REQ-034 Add 0x5555 + 0xAAAA with cin=0 on requester 0 -> resp_sum=0xFFFF, resp_cout=0, resp_id=0, with resp_valid 4 edges after accept.
REQ-035 Add 0xFFFF + 0xFFFF with cin=1 -> resp_sum=0xFFFF, resp_cout=1.
REQ-036 Add 0x000F + 0x0001 with cin=0 -> resp_sum=0x0010, resp_cout=0, confirming carry passes between slices.
REQ-037 Assert both requesters on the first cycle after reset -> requester 0 is served first (id=0), then requester 1 (id=1) once IDLE is re-entered.
REQ-038 Hold resp_ready low for 3 cycles in DONE -> resp_valid, resp_sum and resp_id stay stable, and req_ready stays 0 throughout.
REQ-039 Assert rst during slice k=2 -> the next cycle shows IDLE, resp_valid=0, resp_sum=0, and no response is ever issued for that operation.
